gate_exhaustive_checker: RTL and testbench

//  Sequential stimulus/response stage for the 2-input gate cells (inverter, NAND, NOR).
//  - Upstream side: drives every input vector 00,01,10,11 into the gates.
//  - Downstream side: samples the three gate outputs and compares each against its truth table.
//  - Reports per-vector and per-gate failures and a saturating error count.

---
 rtl/gate_exhaustive_checker_if.sv | 34 +++
 rtl/gate_exhaustive_checker.sv | 168 ++++++++++++++++
 tb/tb_gate_exhaustive_checker.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_exhaustive_checker_if.sv
// ---------------------------------------------------------------------------
// gate_exhaustive_checker_if
// Connects the checker to the gate cells under test (inverter, NAND, NOR).
//   dut_in1   gate input A (inverter input, NAND/NOR in1)
//   dut_in2   gate input B (NAND/NOR in2)
//   inv_out   inverter output
//   nand_out  NAND output
//   nor_out   NOR output
// master: the checker (drives the inputs, samples the outputs)
// slave : the gate side (consumes the inputs, returns the outputs)
// ---------------------------------------------------------------------------
interface gate_exhaustive_checker_if;
   logic dut_in1;
   logic dut_in2;
   logic inv_out;
   logic nand_out;
   logic nor_out;

   modport master (
      output dut_in1,
      output dut_in2,
      input  inv_out,
      input  nand_out,
      input  nor_out
   );

   modport slave (
      input  dut_in1,
      input  dut_in2,
      output inv_out,
      output nand_out,
      output nor_out
   );
endinterface

// File: rtl/gate_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// gate_exhaustive_checker
// Exhaustive stimulus/response checker for an inverter, a NAND and a NOR.
// Applies the vectors 00,01,10,11 in turn. Each vector is held for
// SETTLE_CYCLES clocks before the gate outputs are compared against their
// truth tables. The results are reported when the run ends.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, accepted only while idle
//   gate       gate bus (master side): dut_in1/dut_in2 out, gate outputs in
//   busy       high while vectors are being applied and sampled
//   done       one-cycle pulse at the end of a run
//   pass       last run had no mismatches (held until next accepted start)
//   err_count  saturating count of gate mismatches in the last run
//   fail_vec   bit v set if any gate mismatched on vector v = {in1,in2}
//   fail_gate  sticky {nor,nand,inv} mismatch flags for the last run
// ---------------------------------------------------------------------------
module gate_exhaustive_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   gate_exhaustive_checker_if.master   gate,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [ERR_W-1:0]            err_count,
   output logic [3:0]                  fail_vec,
   output logic [2:0]                  fail_gate
);

   localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         v_q, v_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [3:0]         fvec_q, fvec_d;
   logic [2:0]         fgate_q, fgate_d;
   logic               pass_q, pass_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [2:0]         mis;
   logic [1:0]         mis_cnt;

   // Saturating accumulate of 0..3 mismatches into the error counter.
   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                input logic [1:0]       b);
      logic [ERR_W:0] s;
      s = {1'b0, a} + {{(ERR_W-1){1'b0}}, b};
      return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
   endfunction

   // Mismatch bits {nor,nand,inv} of the live gate outputs against the
   // truth table of the vector currently driven.
   always_comb begin
      mis[0] = gate.inv_out  ^ ~v_q[1];
      mis[1] = gate.nand_out ^ ~(v_q[1] & v_q[0]);
      mis[2] = gate.nor_out  ^ ~(v_q[1] | v_q[0]);
      mis_cnt = {1'b0, mis[0]} + {1'b0, mis[1]} + {1'b0, mis[2]};
   end

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fgate_d = fgate_q;
      pass_d  = pass_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               v_d     = 2'd0;
               err_d   = '0;
               fvec_d  = 4'd0;
               fgate_d = 3'd0;
               pass_d  = 1'b0;
               state_d = S_APPLY;
            end
         end
         S_APPLY: begin
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
         end
         S_SETTLE: begin
            // The counter is loaded with SETTLE_CYCLES, so leaving at 1
            // gives exactly SETTLE_CYCLES cycles in this state.
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            err_d       = sat_add(err_q, mis_cnt);
            fvec_d[v_q] = fvec_q[v_q] | (|mis);
            fgate_d     = fgate_q | mis;
            if (v_q == 2'd3) begin
               // pass must already be valid while done is high.
               pass_d  = ((fgate_q | mis) == 3'd0);
               state_d = S_DONE;
            end else begin
               v_d     = v_q + 2'd1;
               state_d = S_APPLY;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         v_q     <= 2'd0;
         cnt_q   <= '0;
         err_q   <= '0;
         fvec_q  <= 4'd0;
         fgate_q <= 3'd0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fgate_q <= fgate_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign gate.dut_in1 = v_q[1];
   assign gate.dut_in2 = v_q[0];
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_vec     = fvec_q;
   assign fail_gate    = fgate_q;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_exhaustive_checker
// Two checkers: A with defaults (SETTLE_CYCLES=2, ERR_W=8) and B with
// SETTLE_CYCLES=0, ERR_W=2. Both see the same start/reset and the same
// fault configuration on their own set of modelled gates. A run-level model
// predicts every output from the cycle count since the accepting edge.
// ---------------------------------------------------------------------------
module tb_gate_exhaustive_checker;

   localparam int S_A = 2;
   localparam int W_A = 8;
   localparam int S_B = 0;
   localparam int W_B = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   // Fault mode per gate, 2 bits each {nor,nand,inv}:
   // 0 = correct, 1 = stuck 0, 2 = stuck 1, 3 = inverted
   logic [5:0] cfg   = 6'd0;

   always #5 clk = ~clk;

   gate_exhaustive_checker_if if_a ();
   gate_exhaustive_checker_if if_b ();

   function automatic logic faulty(input logic [1:0] mode, input logic good);
      case (mode)
         2'd0:    return good;
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         default: return ~good;
      endcase
   endfunction

   assign if_a.inv_out  = faulty(cfg[1:0], ~if_a.dut_in1);
   assign if_a.nand_out = faulty(cfg[3:2], ~(if_a.dut_in1 & if_a.dut_in2));
   assign if_a.nor_out  = faulty(cfg[5:4], ~(if_a.dut_in1 | if_a.dut_in2));
   assign if_b.inv_out  = faulty(cfg[1:0], ~if_b.dut_in1);
   assign if_b.nand_out = faulty(cfg[3:2], ~(if_b.dut_in1 & if_b.dut_in2));
   assign if_b.nor_out  = faulty(cfg[5:4], ~(if_b.dut_in1 | if_b.dut_in2));

   logic           busy_a, done_a, pass_a;
   logic [W_A-1:0] err_a;
   logic [3:0]     fv_a;
   logic [2:0]     fg_a;
   logic           busy_b, done_b, pass_b;
   logic [W_B-1:0] err_b;
   logic [3:0]     fv_b;
   logic [2:0]     fg_b;

   gate_exhaustive_checker #(.SETTLE_CYCLES(S_A), .ERR_W(W_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .gate(if_a),
      .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .fail_vec(fv_a), .fail_gate(fg_a)
   );

   gate_exhaustive_checker #(.SETTLE_CYCLES(S_B), .ERR_W(W_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .gate(if_b),
      .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .fail_vec(fv_b), .fail_gate(fg_b)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int settle_of(input int i);
      return (i == 0) ? S_A : S_B;
   endfunction

   function automatic int width_of(input int i);
      return (i == 0) ? W_A : W_B;
   endfunction

   // Mismatch bits {nor,nand,inv} the faulty gates produce on vector v.
   function automatic logic [2:0] mis_of(input int v, input logic [5:0] c);
      logic a, b, gi, gn, go;
      a  = (v >= 2);
      b  = (v % 2) == 1;
      gi = !a;
      gn = !(a && b);
      go = !(a || b);
      return {faulty(c[5:4], go) != go, faulty(c[3:2], gn) != gn, faulty(c[1:0], gi) != gi};
   endfunction

   // Expected outputs t cycles after the accepting edge of a run.
   function automatic void model_out(input int s, input int w, input bit ran, input int t,
                                     input logic [5:0] c,
                                     output int busy, output int done, output int pass,
                                     output int vin, output int err,
                                     output int fv, output int fg);
      int n, k, sum, mx;
      logic [2:0] m;
      busy = 0; done = 0; pass = 0; vin = 0; err = 0; fv = 0; fg = 0;
      if (!ran) return;
      n    = 4 * (s + 2);
      busy = (t < n);
      done = (t == n);
      vin  = (t < n) ? t / (s + 2) : 3;
      k    = t / (s + 2);
      if (k > 4) k = 4;
      sum  = 0;
      for (int v = 0; v < k; v++) begin
         m   = mis_of(v, c);
         sum = sum + m[0] + m[1] + m[2];
         if (m != 3'd0) fv = fv | (1 << v);
         fg = fg | m;
      end
      mx   = (1 << w) - 1;
      err  = (sum > mx) ? mx : sum;
      pass = (t >= n) && (fg == 0);
   endfunction

   bit         ran_m [2];
   int         t_m   [2];
   logic [5:0] cfg_m [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            ran_m[i] <= 1'b0;
            t_m[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if ((!ran_m[i] || t_m[i] > 4 * (settle_of(i) + 2)) && start) begin
               ran_m[i] <= 1'b1;
               t_m[i]   <= 0;
               cfg_m[i] <= cfg;
            end else if (ran_m[i] && t_m[i] <= 4 * (settle_of(i) + 2)) begin
               t_m[i] <= t_m[i] + 1;
            end
         end
      end
   end

   // Every-cycle compare of both checkers against the model.
   always @(negedge clk) begin
      int eb, ed, ep, ev, ee, ef, eg;
      for (int i = 0; i < 2; i++) begin
         model_out(settle_of(i), width_of(i), ran_m[i], t_m[i], cfg_m[i],
                   eb, ed, ep, ev, ee, ef, eg);
         if (i == 0) begin
            chk("a_busy", int'(busy_a), eb);
            chk("a_done", int'(done_a), ed);
            chk("a_pass", int'(pass_a), ep);
            chk("a_dut_in", int'({if_a.dut_in1, if_a.dut_in2}), ev);
            chk("a_err_count", int'(err_a), ee);
            chk("a_fail_vec", int'(fv_a), ef);
            chk("a_fail_gate", int'(fg_a), eg);
         end else begin
            chk("b_busy", int'(busy_b), eb);
            chk("b_done", int'(done_b), ed);
            chk("b_pass", int'(pass_b), ep);
            chk("b_dut_in", int'({if_b.dut_in1, if_b.dut_in2}), ev);
            chk("b_err_count", int'(err_b), ee);
            chk("b_fail_vec", int'(fv_b), ef);
            chk("b_fail_gate", int'(fg_b), eg);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_dir(input string nm, input logic [5:0] c, input int e_err,
                          input int e_fv, input int e_fg, input int e_pass,
                          input int e_errb, input bit repulse);
      int ca, cb;
      cfg   = c;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      ca = 0;
      cb = -1;
      @(negedge clk);
      while (ca < 40 && !done_a) begin
         if (done_b && cb < 0) cb = ca;
         if (repulse && ca == 3) start = 1'b1;
         if (repulse && ca == 4) start = 1'b0;
         @(negedge clk);
         ca++;
      end
      chk({nm, "_done_latency_a"}, ca, 16);
      chk({nm, "_done_latency_b"}, cb, 8);
      chk({nm, "_err_a"}, int'(err_a), e_err);
      chk({nm, "_fail_vec_a"}, int'(fv_a), e_fv);
      chk({nm, "_fail_gate_a"}, int'(fg_a), e_fg);
      chk({nm, "_pass_a"}, int'(pass_a), e_pass);
      chk({nm, "_err_b"}, int'(err_b), e_errb);
      repeat (4) tick();
   endtask

   initial begin
      int eb, ed, ep, ev, ee, ef, eg, nd, len;

      // Hand-computed pins on the model itself.
      model_out(2, 8, 1'b1, 16, 6'b010101, eb, ed, ep, ev, ee, ef, eg);
      chk("model_all0_err", ee, 6);
      chk("model_all0_fv", ef, 7);
      chk("model_all0_fg", eg, 7);
      chk("model_all0_done", ed, 1);
      model_out(0, 2, 1'b1, 8, 6'b010101, eb, ed, ep, ev, ee, ef, eg);
      chk("model_sat_err", ee, 3);
      model_out(2, 8, 1'b1, 5, 6'b000001, eb, ed, ep, ev, ee, ef, eg);
      chk("model_partial_err", ee, 1);
      chk("model_partial_vin", ev, 1);

      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy_a), 0);
      chk("reset_err", int'(err_a), 0);
      chk("reset_dut_in", int'({if_a.dut_in1, if_a.dut_in2}), 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      run_dir("good",      6'b000000, 0, 4'b0000, 3'b000, 1, 0, 1'b0);
      run_dir("nand_st1",  6'b001000, 1, 4'b1000, 3'b010, 0, 1, 1'b0);
      run_dir("inv_st0",   6'b000001, 2, 4'b0011, 3'b001, 0, 2, 1'b0);
      run_dir("all_st0",   6'b010101, 6, 4'b0111, 3'b111, 0, 3, 1'b0);
      run_dir("repulse",   6'b000000, 0, 4'b0000, 3'b000, 1, 0, 1'b1);

      // Reset in the middle of a run.
      cfg   = 6'b010101;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", int'(busy_a), 0);
      chk("midrst_err", int'(err_a), 0);
      chk("midrst_fail_gate", int'(fg_a), 0);
      chk("midrst_dut_in", int'({if_a.dut_in1, if_a.dut_in2}), 0);
      tick();
      rst_n = 1'b1;
      nd = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_a || done_b) nd++;
      end
      chk("midrst_no_done", nd, 0);
      tick();
      run_dir("after_rst", 6'b000000, 0, 4'b0000, 3'b000, 1, 0, 1'b0);

      // Randomised runs with stray start pulses and occasional resets.
      for (int it = 0; it < 30; it++) begin
         cfg   = 6'($urandom);
         tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         len   = $urandom_range(0, 25);
         for (int k = 0; k < len; k++) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) begin
               rst_n = 1'b0;
               tick();
               rst_n = 1'b1;
            end
            tick();
         end
         start = 1'b0;
         repeat (22) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
